rs_issue_queue: RTL and testbench

Parametrised reservation-station issue stage between decode/rename and the functional units. Accepts one dispatched instruction per cycle into a per-FU, age-ordered queue of RS_DEPTH entries. Entries capture source operands from the PRF or the CDB broadcast, and each FU issues its oldest fully-ready entry when not busy. Adds back-pressure, age-ordered select, CDB capture at dispatch and pipeline flush.

---
 rtl/rs_issue_queue.sv | 229 ++++++++++++++++++++++
 tb/tb_rs_issue_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_queue.sv
// rs_issue_queue: per-FU reservation-station issue stage.
// Each FU owns a compacting, age-ordered queue of RS_DEPTH entries (slot 0 is
// oldest). Sources are captured from the PRF, from the CDB at dispatch, or by a
// later CDB wakeup. Each FU issues its oldest fully-ready entry when not busy.
// Optional macro RS_WAKEUP_BYPASS_EN: select also honours a same-cycle CDB match
// and substitutes cdb_val on the issued operand.
module rs_issue_queue #(
    parameter int FU_COUNT = 8,
    parameter int RS_DEPTH = 4,
    parameter int DATA_W   = 8,
    parameter int TAG_W    = 4,
    parameter int ROB_W    = 4,
    parameter int FU_W     = $clog2(FU_COUNT)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   disp_valid,
    output logic                                   disp_ready,
    input  logic [FU_W-1:0]                        disp_fu,
    input  logic [7:0]                             disp_op,
    input  logic [7:0]                             disp_wbs,
    input  logic [7:0]                             disp_flags,
    input  logic [ROB_W-1:0]                       disp_robid,
    input  logic [2*TAG_W-1:0]                     disp_src_tag,
    input  logic [1:0]                             disp_src_rdy,
    input  logic [2*DATA_W-1:0]                    disp_src_val,
    input  logic                                   cdb_valid,
    input  logic [TAG_W-1:0]                       cdb_tag,
    input  logic [DATA_W-1:0]                      cdb_val,
    input  logic [FU_COUNT-1:0]                    fu_busy,
    output logic [FU_COUNT-1:0]                    iss_valid,
    output logic [FU_COUNT*8-1:0]                  iss_op,
    output logic [FU_COUNT*8-1:0]                  iss_wbs,
    output logic [FU_COUNT*8-1:0]                  iss_flags,
    output logic [FU_COUNT*ROB_W-1:0]              iss_robid,
    output logic [FU_COUNT*2*DATA_W-1:0]           iss_src_val,
    output logic [FU_COUNT*$clog2(RS_DEPTH+1)-1:0] rs_count
);

    localparam int CW = $clog2(RS_DEPTH + 1);
    localparam int IW = $clog2(RS_DEPTH);

`ifdef RS_WAKEUP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic                   valid;
        logic [7:0]             op;
        logic [7:0]             wbs;
        logic [7:0]             flags;
        logic [ROB_W-1:0]       robid;
        logic [1:0]             rdy;
        logic [1:0][TAG_W-1:0]  tag;
        logic [1:0][DATA_W-1:0] val;
    } entry_t;

    entry_t           q_r   [FU_COUNT][RS_DEPTH];
    entry_t           q_nxt [FU_COUNT][RS_DEPTH];
    entry_t           woke  [FU_COUNT][RS_DEPTH];
    logic [CW-1:0]    cnt_r   [FU_COUNT];
    logic [CW-1:0]    cnt_nxt [FU_COUNT];
    logic [FU_COUNT-1:0] sel_found;
    logic [IW-1:0]    sel_idx [FU_COUNT];
    entry_t           new_entry;
    logic             disp_fire;

    // A source counts as ready for select if captured, or (bypass build) hit by the CDB now.
    function automatic logic src_ready(input entry_t e, input int s,
                                       input logic cv, input logic [TAG_W-1:0] ct);
        return e.rdy[s] || (BYPASS && cv && (e.tag[s] == ct));
    endfunction

    // Back-pressure uses occupancy before any same-cycle issue.
    assign disp_ready = !rst && !flush && (cnt_r[disp_fu] < CW'(RS_DEPTH));
    assign disp_fire  = disp_valid && disp_ready;

    // Build the incoming entry, capturing a same-cycle CDB broadcast to avoid lost wakeups.
    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.op    = disp_op;
        new_entry.wbs   = disp_wbs;
        new_entry.flags = disp_flags;
        new_entry.robid = disp_robid;
        for (int s = 0; s < 2; s++) begin
            new_entry.tag[s] = disp_src_tag[s*TAG_W +: TAG_W];
            if (disp_src_rdy[s]) begin
                new_entry.rdy[s] = 1'b1;
                new_entry.val[s] = disp_src_val[s*DATA_W +: DATA_W];
            end else if (cdb_valid && (cdb_tag == disp_src_tag[s*TAG_W +: TAG_W])) begin
                new_entry.rdy[s] = 1'b1;
                new_entry.val[s] = cdb_val;
            end else begin
                new_entry.rdy[s] = 1'b0;
                new_entry.val[s] = '0;
            end
        end
    end

    // Oldest-first select: lowest slot whose two sources are both ready.
    always_comb begin
        for (int f = 0; f < FU_COUNT; f++) begin
            sel_found[f] = 1'b0;
            sel_idx[f]   = '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (!sel_found[f] && q_r[f][i].valid &&
                    src_ready(q_r[f][i], 0, cdb_valid, cdb_tag) &&
                    src_ready(q_r[f][i], 1, cdb_valid, cdb_tag)) begin
                    sel_found[f] = 1'b1;
                    sel_idx[f]   = IW'(i);
                end else begin
                    sel_found[f] = sel_found[f];
                end
            end
        end
    end

    // Drive issue outputs from the selected entry; zero whenever nothing issues.
    always_comb begin
        entry_t sel_e;
        sel_e       = '0;
        iss_valid   = '0;
        iss_op      = '0;
        iss_wbs     = '0;
        iss_flags   = '0;
        iss_robid   = '0;
        iss_src_val = '0;
        for (int f = 0; f < FU_COUNT; f++) begin
            if (!rst && !flush && !fu_busy[f] && sel_found[f]) begin
                sel_e                        = q_r[f][sel_idx[f]];
                iss_valid[f]                 = 1'b1;
                iss_op[f*8 +: 8]             = sel_e.op;
                iss_wbs[f*8 +: 8]            = sel_e.wbs;
                iss_flags[f*8 +: 8]          = sel_e.flags;
                iss_robid[f*ROB_W +: ROB_W]  = sel_e.robid;
                for (int s = 0; s < 2; s++) begin
                    // A selected source that is not yet captured can only be a bypass hit.
                    iss_src_val[(f*2+s)*DATA_W +: DATA_W] = sel_e.rdy[s] ? sel_e.val[s] : cdb_val;
                end
            end else begin
                iss_valid[f] = 1'b0;
            end
        end
    end

    // Apply CDB wakeup to every waiting source of every queued entry.
    always_comb begin
        for (int f = 0; f < FU_COUNT; f++) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                woke[f][i] = q_r[f][i];
                for (int s = 0; s < 2; s++) begin
                    if (q_r[f][i].valid && !q_r[f][i].rdy[s] && cdb_valid &&
                        (q_r[f][i].tag[s] == cdb_tag)) begin
                        woke[f][i].rdy[s] = 1'b1;
                        woke[f][i].val[s] = cdb_val;
                    end else begin
                        woke[f][i].rdy[s] = q_r[f][i].rdy[s];
                    end
                end
            end
        end
    end

    // Next queue contents: compact out the issued slot, then append the dispatch at the new tail.
    always_comb begin
        logic [CW-1:0] base;
        base = '0;
        for (int f = 0; f < FU_COUNT; f++) begin
            for (int i = 0; i < RS_DEPTH - 1; i++) begin
                if (iss_valid[f] && (IW'(i) >= sel_idx[f])) begin
                    q_nxt[f][i] = woke[f][i+1];
                end else begin
                    q_nxt[f][i] = woke[f][i];
                end
            end
            if (iss_valid[f]) begin
                q_nxt[f][RS_DEPTH-1] = '0;
            end else begin
                q_nxt[f][RS_DEPTH-1] = woke[f][RS_DEPTH-1];
            end
            base       = cnt_r[f] - CW'(iss_valid[f]);
            cnt_nxt[f] = base;
            if (disp_fire && (disp_fu == FU_W'(f))) begin
                cnt_nxt[f] = base + CW'(1);
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (CW'(i) == base) begin
                        q_nxt[f][i] = new_entry;
                    end else begin
                        q_nxt[f][i] = q_nxt[f][i];
                    end
                end
            end else begin
                cnt_nxt[f] = base;
            end
        end
    end

    // Queue state registers; reset and flush empty every queue and outrank all updates.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int f = 0; f < FU_COUNT; f++) begin
                cnt_r[f] <= '0;
                for (int i = 0; i < RS_DEPTH; i++) begin
                    q_r[f][i] <= '0;
                end
            end
        end else begin
            for (int f = 0; f < FU_COUNT; f++) begin
                cnt_r[f] <= cnt_nxt[f];
                for (int i = 0; i < RS_DEPTH; i++) begin
                    q_r[f][i] <= q_nxt[f][i];
                end
            end
        end
    end

    // Pack per-queue occupancy onto the flat output bus.
    always_comb begin
        rs_count = '0;
        for (int f = 0; f < FU_COUNT; f++) begin
            rs_count[f*CW +: CW] = cnt_r[f];
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed self-checking bench for rs_issue_queue.
`timescale 1ns/1ps
module tb_rs_issue_queue;

    localparam int FC = 8;
    localparam int DW = 8;
    localparam int TW = 4;
    localparam int RW = 4;
    localparam int FW = 3;
    localparam int CW = 3;

    logic                 clk = 1'b0;
    logic                 rst, flush, disp_valid, disp_ready;
    logic [FW-1:0]        disp_fu;
    logic [7:0]           disp_op, disp_wbs, disp_flags;
    logic [RW-1:0]        disp_robid;
    logic [2*TW-1:0]      disp_src_tag;
    logic [1:0]           disp_src_rdy;
    logic [2*DW-1:0]      disp_src_val;
    logic                 cdb_valid;
    logic [TW-1:0]        cdb_tag;
    logic [DW-1:0]        cdb_val;
    logic [FC-1:0]        fu_busy;
    logic [FC-1:0]        iss_valid;
    logic [FC*8-1:0]      iss_op, iss_wbs, iss_flags;
    logic [FC*RW-1:0]     iss_robid;
    logic [FC*2*DW-1:0]   iss_src_val;
    logic [FC*CW-1:0]     rs_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rs_issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_fu(disp_fu),
        .disp_op(disp_op), .disp_wbs(disp_wbs), .disp_flags(disp_flags),
        .disp_robid(disp_robid), .disp_src_tag(disp_src_tag),
        .disp_src_rdy(disp_src_rdy), .disp_src_val(disp_src_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .fu_busy(fu_busy), .iss_valid(iss_valid), .iss_op(iss_op),
        .iss_wbs(iss_wbs), .iss_flags(iss_flags), .iss_robid(iss_robid),
        .iss_src_val(iss_src_val), .rs_count(rs_count)
    );

    task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic dsp(input logic [2:0] fu, input logic [3:0] rob, input logic [7:0] op,
                       input logic [1:0] rdy, input logic [3:0] t0, input logic [3:0] t1,
                       input logic [7:0] v0, input logic [7:0] v1);
        disp_valid   = 1'b1;
        disp_fu      = fu;
        disp_robid   = rob;
        disp_op      = op;
        disp_wbs     = {4'h0, rob};
        disp_flags   = {rob, 4'h0};
        disp_src_rdy = rdy;
        disp_src_tag = {t1, t0};
        disp_src_val = {v1, v0};
    endtask

    task automatic nxt();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_fu = '0;
        disp_op = '0; disp_wbs = '0; disp_flags = '0; disp_robid = '0;
        disp_src_tag = '0; disp_src_rdy = '0; disp_src_val = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; fu_busy = '0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_disp_ready", disp_ready, 1'b0);
        nxt(); nxt();
        rst = 1'b0; #1;
        chk("rst_count", rs_count, 24'h0);
        chk("rst_iss_valid", iss_valid, 8'h00);
        chk("rst_iss_op", iss_op, 64'h0);
        chk("rst_iss_src_val", iss_src_val, 128'h0);
        chk("rst_ready_after", disp_ready, 1'b1);

        // Back-to-back dispatch to FU 2
        dsp(3'd2, 4'd1, 8'h11, 2'b11, 4'd0, 4'd0, 8'h12, 8'h34); #1;
        chk("b2b_ready", disp_ready, 1'b1);
        chk("b2b_noiss0", iss_valid, 8'h00);
        nxt(); dsp(3'd2, 4'd2, 8'h22, 2'b11, 4'd0, 4'd0, 8'h56, 8'h78); #1;
        chk("b2b_v1", iss_valid, 8'h04);
        chk("b2b_rob1", iss_robid[2*RW +: RW], 4'd1);
        chk("b2b_op1", iss_op[2*8 +: 8], 8'h11);
        chk("b2b_wbs1", iss_wbs[2*8 +: 8], 8'h01);
        chk("b2b_flags1", iss_flags[2*8 +: 8], 8'h10);
        chk("b2b_src1", iss_src_val[2*2*DW +: 2*DW], 16'h3412);
        chk("b2b_cnt1", rs_count[2*CW +: CW], 3'd1);
        nxt(); dsp(3'd2, 4'd3, 8'h33, 2'b11, 4'd0, 4'd0, 8'h01, 8'h02); #1;
        chk("b2b_rob2", iss_robid[2*RW +: RW], 4'd2);
        chk("b2b_cnt2", rs_count[2*CW +: CW], 3'd1);
        nxt(); dsp(3'd2, 4'd4, 8'h44, 2'b11, 4'd0, 4'd0, 8'h03, 8'h04); #1;
        chk("b2b_rob3", iss_robid[2*RW +: RW], 4'd3);
        nxt(); disp_valid = 1'b0; #1;
        chk("b2b_v4", iss_valid, 8'h04);
        chk("b2b_rob4", iss_robid[2*RW +: RW], 4'd4);
        chk("b2b_src4", iss_src_val[2*2*DW +: 2*DW], 16'h0403);
        nxt(); #1;
        chk("b2b_empty_v", iss_valid, 8'h00);
        chk("b2b_empty_c", rs_count[2*CW +: CW], 3'd0);

        // Full queue on FU 0 with FU busy
        fu_busy = 8'h01;
        dsp(3'd0, 4'd5, 8'h50, 2'b11, 4'd0, 4'd0, 8'h05, 8'h05); nxt();
        dsp(3'd0, 4'd6, 8'h60, 2'b11, 4'd0, 4'd0, 8'h06, 8'h06); nxt();
        dsp(3'd0, 4'd7, 8'h70, 2'b11, 4'd0, 4'd0, 8'h07, 8'h07); nxt();
        dsp(3'd0, 4'd8, 8'h80, 2'b11, 4'd0, 4'd0, 8'h08, 8'h08); #1;
        chk("full_ready3", disp_ready, 1'b1);
        nxt(); disp_valid = 1'b0; disp_fu = 3'd0; #1;
        chk("full_cnt4", rs_count[0 +: CW], 3'd4);
        chk("full_ready0", disp_ready, 1'b0);
        chk("full_busy_noiss", iss_valid, 8'h00);
        disp_fu = 3'd1; #1;
        chk("full_ready_other", disp_ready, 1'b1);
        disp_fu = 3'd0; fu_busy = 8'h00; #1;
        chk("full_iss_v", iss_valid, 8'h01);
        chk("full_iss_rob", iss_robid[0 +: RW], 4'd5);
        nxt(); #1;
        chk("full_cnt3", rs_count[0 +: CW], 3'd3);
        chk("full_ready_back", disp_ready, 1'b1);
        chk("full_rob6", iss_robid[0 +: RW], 4'd6);
        nxt(); nxt(); nxt(); #1;
        chk("full_drained", rs_count[0 +: CW], 3'd0);

        // Age order with wakeup on FU 3
        dsp(3'd3, 4'd9, 8'h90, 2'b10, 4'd5, 4'd0, 8'h00, 8'h01); #1;
        chk("age_noiss0", iss_valid, 8'h00);
        nxt(); dsp(3'd3, 4'd10, 8'hA0, 2'b11, 4'd0, 4'd0, 8'h0B, 8'h0C); #1;
        chk("age_a_waits", iss_valid, 8'h00);
        nxt(); disp_valid = 1'b0; #1;
        chk("age_b_v", iss_valid, 8'h08);
        chk("age_b_rob", iss_robid[3*RW +: RW], 4'd10);
        nxt(); cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_val = 8'h3C; #1;
`ifdef RS_WAKEUP_BYPASS_EN
        chk("age_byp_v", iss_valid, 8'h08);
        chk("age_byp_rob", iss_robid[3*RW +: RW], 4'd9);
        chk("age_byp_src", iss_src_val[3*2*DW +: 2*DW], 16'h013C);
        nxt(); cdb_valid = 1'b0; #1;
        chk("age_byp_after", iss_valid, 8'h00);
`else
        chk("age_cdb_noiss", iss_valid, 8'h00);
        chk("age_cdb_cnt", rs_count[3*CW +: CW], 3'd1);
        nxt(); cdb_valid = 1'b0; #1;
        chk("age_a_v", iss_valid, 8'h08);
        chk("age_a_rob", iss_robid[3*RW +: RW], 4'd9);
        chk("age_a_src", iss_src_val[3*2*DW +: 2*DW], 16'h013C);
`endif
        nxt(); #1;
        chk("age_empty", rs_count[3*CW +: CW], 3'd0);

        // CDB capture at dispatch on FU 4
        dsp(3'd4, 4'd11, 8'hB0, 2'b10, 4'd7, 4'd0, 8'h00, 8'h02);
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_val = 8'hA5; #1;
        chk("cap_noiss", iss_valid, 8'h00);
        nxt(); disp_valid = 1'b0; cdb_valid = 1'b0; #1;
        chk("cap_v", iss_valid, 8'h10);
        chk("cap_rob", iss_robid[4*RW +: RW], 4'd11);
        chk("cap_src", iss_src_val[4*2*DW +: 2*DW], 16'h02A5);
        nxt(); #1;
        chk("cap_empty", rs_count[4*CW +: CW], 3'd0);

        // Flush with occupied queues and a dispatch in the flush cycle
        fu_busy = 8'hFF;
        dsp(3'd1, 4'd1, 8'h01, 2'b11, 4'd0, 4'd0, 8'h01, 8'h01); nxt();
        dsp(3'd1, 4'd2, 8'h02, 2'b11, 4'd0, 4'd0, 8'h02, 8'h02); nxt();
        dsp(3'd1, 4'd3, 8'h03, 2'b11, 4'd0, 4'd0, 8'h03, 8'h03); nxt();
        dsp(3'd5, 4'd4, 8'h04, 2'b11, 4'd0, 4'd0, 8'h04, 8'h04); nxt();
        dsp(3'd5, 4'd5, 8'h05, 2'b11, 4'd0, 4'd0, 8'h05, 8'h05); nxt();
        dsp(3'd6, 4'd12, 8'hC0, 2'b11, 4'd0, 4'd0, 8'h0C, 8'h0C);
        flush = 1'b1; #1;
        chk("fl_cnt1", rs_count[1*CW +: CW], 3'd3);
        chk("fl_cnt5", rs_count[5*CW +: CW], 3'd2);
        chk("fl_ready", disp_ready, 1'b0);
        chk("fl_noiss", iss_valid, 8'h00);
        nxt(); flush = 1'b0; disp_valid = 1'b0; fu_busy = 8'h00; #1;
        chk("fl_counts", rs_count, 24'h0);
        chk("fl_iss", iss_valid, 8'h00);

        // Reset mid-operation
        fu_busy = 8'hFF;
        dsp(3'd7, 4'd13, 8'hD0, 2'b00, 4'd3, 4'd3, 8'h00, 8'h00); nxt();
        dsp(3'd0, 4'd14, 8'hE0, 2'b11, 4'd0, 4'd0, 8'h0E, 8'h0E); nxt();
        disp_valid = 1'b0;
        chk("mr_cnt_before", rs_count, 24'h200001);
        rst = 1'b1; fu_busy = 8'h00; disp_fu = 3'd0; #1;
        chk("mr_ready_in_rst", disp_ready, 1'b0);
        nxt(); rst = 1'b0; #1;
        chk("mr_counts", rs_count, 24'h0);
        chk("mr_iss_v", iss_valid, 8'h00);
        chk("mr_iss_op", iss_op, 64'h0);
        chk("mr_iss_wbs", iss_wbs, 64'h0);
        chk("mr_iss_flags", iss_flags, 64'h0);
        chk("mr_iss_rob", iss_robid, 32'h0);
        chk("mr_iss_src", iss_src_val, 128'h0);
        chk("mr_ready", disp_ready, 1'b1);
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_val = 8'h77;
        nxt(); cdb_valid = 1'b0; #1;
        chk("mr_no_ghost", iss_valid, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
